// File: rtl/mux32_to_1_pkg.sv
// Shared constants for the 32:1 registered mux: width defaults, source count, port-to-index map.
// No latency, no flow control; constants only.
package mux32_to_1_pkg;

  localparam int DW_DEF = 17;
  localparam int SW_DEF = 8;
  localparam int NSRC   = 32;
  localparam int IW     = $clog2(NSRC);

  localparam int IDX_AA = 0;
  localparam int IDX_AB = 1;
  localparam int IDX_AC = 2;
  localparam int IDX_AD = 3;
  localparam int IDX_AE = 4;
  localparam int IDX_AF = 5;
  localparam int IDX_AG = 6;
  localparam int IDX_AH = 7;
  localparam int IDX_AI = 8;
  localparam int IDX_AJ = 9;
  localparam int IDX_BA = 10;
  localparam int IDX_BB = 11;
  localparam int IDX_BC = 12;
  localparam int IDX_BD = 13;
  localparam int IDX_BE = 14;
  localparam int IDX_BF = 15;
  localparam int IDX_BG = 16;
  localparam int IDX_BH = 17;
  localparam int IDX_BI = 18;
  localparam int IDX_BJ = 19;
  localparam int IDX_CA = 20;
  localparam int IDX_CB = 21;
  localparam int IDX_CC = 22;
  localparam int IDX_CD = 23;
  localparam int IDX_CE = 24;
  localparam int IDX_CF = 25;
  localparam int IDX_CG = 26;
  localparam int IDX_CH = 27;
  localparam int IDX_CI = 28;
  localparam int IDX_CJ = 29;
  localparam int IDX_DA = 30;
  localparam int IDX_DB = 31;

endpackage

// File: rtl/mux32_core.sv
// Pure combinational 32:1 selector; any sel >= 32 yields all zeros.
// Zero latency, no flow control.
module mux32_core
  import mux32_to_1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [NSRC-1:0][DW-1:0] src_dat,
  input  logic [SW-1:0]           sel,
  output logic [DW-1:0]           sel_dat
);

  // Compare the full sel width so out-of-range indices never alias onto a source.
  localparam logic [SW:0] NSRC_W = (SW+1)'(NSRC);

  always_comb begin
    sel_dat = '0;
    if ({1'b0, sel} < NSRC_W) begin
      sel_dat = src_dat[sel[IW-1:0]];
    end
  end

endmodule

// File: rtl/mux32_to_1.sv
// Registered 32:1 mux of named sources aa..db; one-cycle latency from sel/data to y.
// No backpressure: y reloads every clock, async reset clears it to zero.
module mux32_to_1
  import mux32_to_1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] aa,
  input  logic [DW-1:0] ab,
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] ad,
  input  logic [DW-1:0] ae,
  input  logic [DW-1:0] af,
  input  logic [DW-1:0] ag,
  input  logic [DW-1:0] ah,
  input  logic [DW-1:0] ai,
  input  logic [DW-1:0] aj,
  input  logic [DW-1:0] ba,
  input  logic [DW-1:0] bb,
  input  logic [DW-1:0] bc,
  input  logic [DW-1:0] bd,
  input  logic [DW-1:0] be,
  input  logic [DW-1:0] bf,
  input  logic [DW-1:0] bg,
  input  logic [DW-1:0] bh,
  input  logic [DW-1:0] bi,
  input  logic [DW-1:0] bj,
  input  logic [DW-1:0] ca,
  input  logic [DW-1:0] cb,
  input  logic [DW-1:0] cc,
  input  logic [DW-1:0] cd,
  input  logic [DW-1:0] ce,
  input  logic [DW-1:0] cf,
  input  logic [DW-1:0] cg,
  input  logic [DW-1:0] ch,
  input  logic [DW-1:0] ci,
  input  logic [DW-1:0] cj,
  input  logic [DW-1:0] da,
  input  logic [DW-1:0] db,
  input  logic [SW-1:0] sel,
  output logic [DW-1:0] y
);

  logic [NSRC-1:0][DW-1:0] src_dat;
  logic [DW-1:0]           sel_dat;

  assign src_dat[IDX_AA] = aa;
  assign src_dat[IDX_AB] = ab;
  assign src_dat[IDX_AC] = ac;
  assign src_dat[IDX_AD] = ad;
  assign src_dat[IDX_AE] = ae;
  assign src_dat[IDX_AF] = af;
  assign src_dat[IDX_AG] = ag;
  assign src_dat[IDX_AH] = ah;
  assign src_dat[IDX_AI] = ai;
  assign src_dat[IDX_AJ] = aj;
  assign src_dat[IDX_BA] = ba;
  assign src_dat[IDX_BB] = bb;
  assign src_dat[IDX_BC] = bc;
  assign src_dat[IDX_BD] = bd;
  assign src_dat[IDX_BE] = be;
  assign src_dat[IDX_BF] = bf;
  assign src_dat[IDX_BG] = bg;
  assign src_dat[IDX_BH] = bh;
  assign src_dat[IDX_BI] = bi;
  assign src_dat[IDX_BJ] = bj;
  assign src_dat[IDX_CA] = ca;
  assign src_dat[IDX_CB] = cb;
  assign src_dat[IDX_CC] = cc;
  assign src_dat[IDX_CD] = cd;
  assign src_dat[IDX_CE] = ce;
  assign src_dat[IDX_CF] = cf;
  assign src_dat[IDX_CG] = cg;
  assign src_dat[IDX_CH] = ch;
  assign src_dat[IDX_CI] = ci;
  assign src_dat[IDX_CJ] = cj;
  assign src_dat[IDX_DA] = da;
  assign src_dat[IDX_DB] = db;

  mux32_core #(
    .DW(DW),
    .SW(SW)
  ) u_core (
    .src_dat(src_dat),
    .sel    (sel),
    .sel_dat(sel_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= sel_dat;
    end
  end

endmodule

// File: tb/tb_mux32_to_1.sv
// Directed-vector bench for mux32_to_1 with hand-computed expected values.
module tb_mux32_to_1;

  localparam int DW = 17;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] src [32];
  logic [SW-1:0] sel;
  logic [DW-1:0] y;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux32_to_1 #(.DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .aa(src[0]),  .ab(src[1]),  .ac(src[2]),  .ad(src[3]),  .ae(src[4]),
    .af(src[5]),  .ag(src[6]),  .ah(src[7]),  .ai(src[8]),  .aj(src[9]),
    .ba(src[10]), .bb(src[11]), .bc(src[12]), .bd(src[13]), .be(src[14]),
    .bf(src[15]), .bg(src[16]), .bh(src[17]), .bi(src[18]), .bj(src[19]),
    .ca(src[20]), .cb(src[21]), .cc(src[22]), .cd(src[23]), .ce(src[24]),
    .cf(src[25]), .cg(src[26]), .ch(src[27]), .ci(src[28]), .cj(src[29]),
    .da(src[30]), .db(src[31]),
    .sel(sel), .y(y)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: y=%h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int k = 0; k < 32; k++) src[k] = v;
  endtask

  initial begin
    // Reset with arbitrary inputs: y must be zero at once and across 3 edges.
    rst = 1'b1;
    sel = 8'd3;
    for (int k = 0; k < 32; k++) src[k] = DW'(17'h1A5A5 ^ (k * 17'h0137));
    #1;
    chk("reset_immediate", y, '0);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("reset_hold_%0d", e), y, '0);
    end

    // First edge after release loads the current selection.
    rst = 1'b0;
    tick();
    chk("release_load", y, DW'(17'h1A5A5 ^ (3 * 17'h0137)));

    // Async assertion mid-cycle clears y without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_assert", y, '0);
    rst = 1'b0;

    // Sweep: source k holds k+100.
    for (int k = 0; k < 32; k++) src[k] = DW'(k + 100);
    for (int s = 0; s < 32; s++) begin
      sel = SW'(s);
      tick();
      chk($sformatf("sweep_%0d", s), y, DW'(s + 100));
    end

    // y must not follow sel between edges.
    sel = 8'd2;
    #2;
    chk("hold_between_edges", y, DW'(131));
    tick();
    chk("hold_then_load", y, DW'(102));

    // Out of range: all sources all-ones, prime y non-zero first.
    fill(17'h1FFFF);
    sel = 8'd31;
    tick();
    chk("oor_prime", y, 17'h1FFFF);
    sel = 8'd32;
    tick();
    chk("oor_32", y, '0);
    sel = 8'd100;
    tick();
    chk("oor_100", y, '0);
    sel = 8'd255;
    tick();
    chk("oor_255", y, '0);

    // Full width on db.
    sel = 8'd31;
    src[31] = 17'h10000;
    tick();
    chk("width_msb", y, 17'h10000);
    src[31] = 17'h0FFFF;
    tick();
    chk("width_low", y, 17'h0FFFF);

    // Isolation: af fixed, every other source toggles (including X).
    sel = 8'd5;
    src[5] = 17'h00ABC;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 32; k++) begin
        if (k != 5) src[k] = (c % 3 == 0) ? 17'h1FFFF : (c % 3 == 1) ? 17'h00000 : 'x;
      end
      tick();
      chk($sformatf("isolate_%0d", c), y, 17'h00ABC);
    end

    // Sel and the new source's data change in the same cycle.
    for (int k = 0; k < 32; k++) src[k] = DW'(k + 100);
    sel = 8'd9;
    src[9] = 17'h15A5A;
    tick();
    chk("sel_and_data_change", y, 17'h15A5A);

    // Mid-sweep reset at sel=17 with bh=0x00077.
    src[9] = DW'(109);
    src[17] = 17'h00077;
    sel = 8'd16;
    tick();
    chk("midsweep_16", y, DW'(116));
    sel = 8'd17;
    tick();
    chk("midsweep_17", y, 17'h00077);
    #2;
    rst = 1'b1;
    #1;
    chk("midsweep_rst_clear", y, '0);
    tick();
    chk("midsweep_rst_edge", y, '0);
    #2;
    rst = 1'b0;
    #1;
    chk("midsweep_no_stale", y, '0);
    tick();
    chk("midsweep_reload", y, 17'h00077);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
